// File: rtl/led_count_alloc.sv
// led_count_alloc
//   Splits a strip of LEDS pixels across BIN_QTY note bins in proportion to
//   each bin's amplitude. One restoring divider is shared by all bins and
//   produces one quotient bit per cycle (QW cycles per bin, bins 0..BIN_QTY-1).
//
//   Optional feature (compile-time macro LED_COUNT_REMAINDER_EN):
//     defined   - leftover pixels go one at a time to the bins with the
//                 largest division remainders (ties to the lowest index), so
//                 the counts sum to LEDS for a consistent nonzero sum.
//     undefined - remainders are dropped; counts are the floor values.
//
// Ports
//   clk                in  clock, all state on the rising edge
//   rst                in  asynchronous active-high reset
//   start              in  request, sampled only while idle
//   noteAmplitudes_i   in  [BIN_QTY][W+D] unsigned fixed-point amplitudes
//   amplitudeSumNew_i  in  [SW] sum of the amplitudes
//   LEDCount           out [BIN_QTY][QW] per-bin LED count, registered
//   data_v             out one-cycle pulse when LEDCount is updated
//   busy               out high whenever a request is in progress
module led_count_alloc #(
    parameter int W       = 5,
    parameter int D       = 11,
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    localparam int QW     = $clog2(LEDS + 1),
    localparam int SW     = W + D + $clog2(BIN_QTY)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [BIN_QTY-1:0][W+D-1:0]      noteAmplitudes_i,
    input  logic [SW-1:0]                    amplitudeSumNew_i,
    output logic [BIN_QTY-1:0][QW-1:0]       LEDCount,
    output logic                             data_v,
    output logic                             busy
);

    localparam int AW = W + D;
    localparam int NW = AW + QW;               // amp*LEDS fits since LEDS < 2^QW
    localparam int BW = $clog2(BIN_QTY);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_DIVIDE     = 2'd1;
`ifdef LED_COUNT_REMAINDER_EN
    localparam logic [1:0] ST_DISTRIBUTE = 2'd2;
    localparam int         LW            = QW + BW;
    localparam logic [LW-1:0] LEDS_L     = LW'(LEDS);
`endif
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic [QW-1:0] CNT_LAST = QW'(QW - 1);
    localparam logic [BW-1:0] BIN_LAST = BW'(BIN_QTY - 1);
    localparam logic [QW-1:0] LEDS_Q   = QW'(LEDS);
    localparam logic [NW-1:0] LEDS_N   = NW'(LEDS);

    logic [1:0]                    state_q, state_d;
    logic [BIN_QTY-1:0][AW-1:0]    amp_q, amp_d;
    logic [SW-1:0]                 sum_q, sum_d;
    logic [BW-1:0]                 bin_q, bin_d;
    logic [QW-1:0]                 cnt_q, cnt_d;
    logic [SW-1:0]                 rem_q, rem_d;
    logic [QW-1:0]                 lo_q, lo_d;
    logic [QW-1:0]                 quo_q, quo_d;
    logic [BIN_QTY-1:0][QW-1:0]    q_q, q_d;
    logic [BIN_QTY-1:0][QW-1:0]    led_count_q, led_count_d;
    logic                          data_v_q, data_v_d;

`ifdef LED_COUNT_REMAINDER_EN
    logic [BIN_QTY-1:0][SW-1:0]    r_q, r_d;
    logic [BIN_QTY-1:0]            mark_q, mark_d;
    logic [LW-1:0]                 qsum_q, qsum_d;
    logic [LW-1:0]                 left_q, left_d;
    logic [LW-1:0]                 qsum_nx;
    logic [LW-1:0]                 left_nx;
    logic                          pick_found;
    logic [BW-1:0]                 pick_idx;
    logic [SW-1:0]                 pick_r;
`endif

    // Divider datapath. On the first cycle of a bin the partial remainder is
    // seeded with amp*LEDS >> QW, which is always below the divisor when
    // amp < sum, so exactly QW quotient bits remain to be produced.
    logic [AW-1:0] amp_cur;
    logic [NW-1:0] num;
    logic [SW-1:0] cur_rem;
    logic [QW-1:0] cur_lo;
    logic [QW-1:0] cur_quo;
    logic [SW:0]   trial;
    logic          q_bit;
    logic [SW-1:0] new_rem;
    logic [QW-1:0] quo_next;
    logic          sat;
    logic [QW-1:0] q_fin;

    always_comb begin
        amp_cur  = amp_q[bin_q];
        num      = NW'(amp_cur) * LEDS_N;
        cur_rem  = (cnt_q == '0) ? SW'(num[NW-1:QW]) : rem_q;
        cur_lo   = (cnt_q == '0) ? num[QW-1:0]       : lo_q;
        cur_quo  = (cnt_q == '0) ? '0                : quo_q;
        trial    = {cur_rem, cur_lo[QW-1]};
        q_bit    = (trial >= {1'b0, sum_q});
        new_rem  = q_bit ? SW'(trial - {1'b0, sum_q}) : SW'(trial);
        quo_next = (cur_quo << 1) | QW'(q_bit);
        // Amplitude at or above the sum would overflow the quotient width.
        sat      = (SW'(amp_cur) >= sum_q);
        q_fin    = sat ? LEDS_Q : quo_next;
    end

`ifdef LED_COUNT_REMAINDER_EN
    // Largest remainder among unmarked bins; strict compare keeps the lowest
    // index on ties, and starting from zero excludes bins with r = 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_r     = '0;
        for (int i = 0; i < BIN_QTY; i++) begin
            if (!mark_q[i] && (r_q[i] > pick_r)) begin
                pick_found = 1'b1;
                pick_idx   = BW'(i);
                pick_r     = r_q[i];
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        amp_d       = amp_q;
        sum_d       = sum_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        quo_d       = quo_q;
        q_d         = q_q;
        led_count_d = led_count_q;
        data_v_d    = 1'b0;
`ifdef LED_COUNT_REMAINDER_EN
        r_d         = r_q;
        mark_d      = mark_q;
        qsum_d      = qsum_q;
        left_d      = left_q;
        qsum_nx     = qsum_q + LW'(q_fin);
        left_nx     = LEDS_L - qsum_nx;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    amp_d  = noteAmplitudes_i;
                    sum_d  = amplitudeSumNew_i;
                    bin_d  = '0;
                    cnt_d  = '0;
                    q_d    = '0;
`ifdef LED_COUNT_REMAINDER_EN
                    r_d    = '0;
                    mark_d = '0;
                    qsum_d = '0;
                    left_d = '0;
`endif
                    state_d = (amplitudeSumNew_i == '0) ? ST_DONE : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                cnt_d = cnt_q + 1'b1;
                rem_d = new_rem;
                lo_d  = cur_lo << 1;
                quo_d = quo_next;
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    q_d[bin_q]   = q_fin;
`ifdef LED_COUNT_REMAINDER_EN
                    r_d[bin_q]   = sat ? '0 : new_rem;
                    qsum_d       = qsum_nx;
`endif
                    if (bin_q == BIN_LAST) begin
`ifdef LED_COUNT_REMAINDER_EN
                        left_d  = left_nx;
                        state_d = (left_nx == '0) ? ST_DONE : ST_DISTRIBUTE;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        bin_d = bin_q + 1'b1;
                    end
                end
            end
`ifdef LED_COUNT_REMAINDER_EN
            ST_DISTRIBUTE: begin
                if (pick_found) begin
                    q_d[pick_idx]    = q_q[pick_idx] + 1'b1;
                    mark_d[pick_idx] = 1'b1;
                    left_d           = left_q - 1'b1;
                    if (left_q == LW'(1)) state_d = ST_DONE;
                end else begin
                    // Inconsistent sum: nothing left to hand out.
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                led_count_d = q_q;
                data_v_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            amp_q       <= '0;
            sum_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            q_q         <= '0;
            led_count_q <= '0;
            data_v_q    <= 1'b0;
`ifdef LED_COUNT_REMAINDER_EN
            r_q         <= '0;
            mark_q      <= '0;
            qsum_q      <= '0;
            left_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            amp_q       <= amp_d;
            sum_q       <= sum_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            quo_q       <= quo_d;
            q_q         <= q_d;
            led_count_q <= led_count_d;
            data_v_q    <= data_v_d;
`ifdef LED_COUNT_REMAINDER_EN
            r_q         <= r_d;
            mark_q      <= mark_d;
            qsum_q      <= qsum_d;
            left_q      <= left_d;
`endif
        end
    end

    assign LEDCount = led_count_q;
    assign data_v   = data_v_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_count_alloc.sv
// Self-checking bench for led_count_alloc (default parameters). The expected
// counts and latency come from a plain-arithmetic model of the allocation
// rules; a per-cycle compare process checks busy, data_v and LEDCount.
module tb_led_count_alloc;

    localparam int BQ   = 12;
    localparam int AW   = 16;
    localparam int QW   = 6;
    localparam int SW   = 20;
    localparam int LEDS = 50;
    localparam int NDIV = BQ * QW;

    typedef logic [BQ-1:0][AW-1:0] amp_t;
    typedef logic [BQ-1:0][QW-1:0] cnt_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    amp_t          amps = '0;
    logic [SW-1:0] sum = '0;
    cnt_t          led_count;
    logic          data_v;
    logic          busy;

    led_count_alloc dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .noteAmplitudes_i  (amps),
        .amplitudeSumNew_i (sum),
        .LEDCount          (led_count),
        .data_v            (data_v),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   fails  = 0;

    // model-side state
    logic pend    = 1'b0;
    int   e0      = 0;
    int   exp_lat = 0;
    cnt_t mdl_cnt = '0;
    cnt_t exp_led = '0;
    int   seen_lat = -1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    // Proportional allocation straight from the rules: floor division with
    // saturation, then hand leftovers to the largest remainders.
    function automatic void model(input amp_t a, input logic [SW-1:0] s,
                                  output cnt_t c, output int lat);
        int     q[BQ];
        longint r[BQ];
        bit     m[BQ];
        int     tot, left, steps, best;
        bit     stop;
        c = '0;
        if (s == 0) begin
            lat = 1;
            return;
        end
        tot = 0;
        for (int i = 0; i < BQ; i++) begin
            m[i] = 0;
            if (a[i] >= s) begin
                q[i] = LEDS;
                r[i] = 0;
            end else begin
                q[i] = int'((longint'(a[i]) * LEDS) / longint'(s));
                r[i] = (longint'(a[i]) * LEDS) % longint'(s);
            end
            tot += q[i];
        end
        steps = 0;
`ifdef LED_COUNT_REMAINDER_EN
        left = (LEDS - tot) & 1023;
        stop = 0;
        while (left > 0 && !stop) begin
            best = -1;
            for (int i = 0; i < BQ; i++)
                if (!m[i] && r[i] > 0 && (best < 0 || r[i] > r[best])) best = i;
            if (best < 0) stop = 1;
            else begin
                q[best]++;
                m[best] = 1;
                left--;
                steps++;
            end
        end
`else
        left = 0;
        stop = 0;
        best = 0;
`endif
        lat = NDIV + steps + 1;
        for (int i = 0; i < BQ; i++) c[i] = q[i][QW-1:0];
    endfunction

    // per-cycle compare, sampled mid-cycle after the rising edge
    initial begin
        logic exp_dv, exp_busy;
        int   el;
        forever begin
            @(posedge clk);
            #3;
            exp_dv   = 1'b0;
            exp_busy = 1'b0;
            if (pend) begin
                el       = cyc - e0;
                exp_dv   = (el == exp_lat);
                exp_busy = (el < exp_lat);
                if (exp_dv) begin
                    exp_led = mdl_cnt;
                    pend    = 1'b0;
                end
            end
            if (data_v === 1'b1) seen_lat = cyc - e0;
            chk("busy",     96'(busy),      96'(exp_busy));
            chk("data_v",   96'(data_v),    96'(exp_dv));
            chk("LEDCount", 96'(led_count), 96'(exp_led));
        end
    end

    task automatic launch(input amp_t a, input logic [SW-1:0] s);
        @(negedge clk);
        amps  = a;
        sum   = s;
        start = 1'b1;
        model(a, s, mdl_cnt, exp_lat);
        e0       = cyc + 1;
        seen_lat = -1;
        pend     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        amps  = ~a;           // inputs are free to change after the request
        sum   = ~s;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (pend && n < budget) begin
            @(posedge clk);
            #4;
            n++;
        end
        if (pend) begin
            chk("timeout", 96'(1), 96'(0));
            pend = 1'b0;
        end
    endtask

    task automatic mid_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        amp_t a;
        cnt_t lit;
        int   tot;
        logic [SW-1:0] s;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // four equal bins: leftover 2 goes to bins 0 and 1
        a = '0;
        for (int i = 0; i < 4; i++) a[i] = 16'h9980;
        launch(a, 20'h26600);
        wait_done(200);
        lit = '0;
`ifdef LED_COUNT_REMAINDER_EN
        lit[0] = 6'd13; lit[1] = 6'd13; lit[2] = 6'd12; lit[3] = 6'd12;
        chk("lat_four_bins", 96'(seen_lat), 96'(75));
        tot = 0;
        for (int i = 0; i < BQ; i++) tot += int'(led_count[i]);
        chk("sum_four_bins", 96'(tot), 96'(50));
`else
        lit[0] = 6'd12; lit[1] = 6'd12; lit[2] = 6'd12; lit[3] = 6'd12;
        chk("lat_four_bins", 96'(seen_lat), 96'(73));
`endif
        chk("lit_four_bins", 96'(led_count), 96'(lit));

        // back-to-back: zero sum launched in the data_v cycle
        for (int i = 0; i < BQ; i++) a[i] = 16'(16'h1234 + i * 16'h0711);
        launch(a, 20'h0);
        wait_done(20);
        chk("lat_zero_sum", 96'(seen_lat), 96'(1));
        chk("lit_zero_sum", 96'(led_count), 96'(0));

        // single bin, sum equals amplitude
        a = '0;
        a[5] = 16'h0800;
        launch(a, 20'h00800);
        wait_done(200);
        chk("lit_single_bin5", 96'(led_count[5]), 96'(50));
        chk("lat_single", 96'(seen_lat), 96'(73));

        // single bin, sum smaller than the amplitude -> saturation
        launch(a, 20'h00400);
        wait_done(200);
        chk("lit_sat_bin5", 96'(led_count[5]), 96'(50));
        lit = '0;
        lit[5] = 6'd50;
        chk("lit_sat_all", 96'(led_count), 96'(lit));

        // three equal bins: floors 16, ties to lowest indices
        a = '0;
        a[0] = 16'h1000; a[4] = 16'h1000; a[8] = 16'h1000;
        launch(a, 20'h03000);
        wait_done(200);
        lit = '0;
`ifdef LED_COUNT_REMAINDER_EN
        lit[0] = 6'd17; lit[4] = 6'd17; lit[8] = 6'd16;
        chk("lat_three_bins", 96'(seen_lat), 96'(75));
`else
        lit[0] = 6'd16; lit[4] = 6'd16; lit[8] = 6'd16;
`endif
        chk("lit_three_bins", 96'(led_count), 96'(lit));

        // spread amplitudes with a consistent sum
        for (int k = 0; k < 2; k++) begin
            s = '0;
            for (int i = 0; i < BQ; i++) begin
                a[i] = 16'((i + 1) * (k == 0 ? 16'h0313 : 16'h0a07) + i * i * 16'h0029);
                s    = s + SW'(a[i]);
            end
            launch(a, s);
            wait_done(200);
        end

        // reset in the middle of a divide, with an ignored start pulse
        a = '0;
        for (int i = 0; i < 4; i++) a[i] = 16'h9980;
        launch(a, 20'h26600);
        repeat (8) @(negedge clk);
        mid_start();
        repeat (18) @(negedge clk);
        rst     = 1'b1;
        pend    = 1'b0;
        exp_led = '0;
        #1;
        chk("rst_busy",   96'(busy),      96'(0));
        chk("rst_data_v", 96'(data_v),    96'(0));
        chk("rst_count",  96'(led_count), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        a = '0;
        a[0] = 16'h1000; a[4] = 16'h1000; a[8] = 16'h1000;
        launch(a, 20'h03000);
        repeat (5) @(negedge clk);
        mid_start();
        wait_done(200);
`ifdef LED_COUNT_REMAINDER_EN
        chk("post_rst_bin0", 96'(led_count[0]), 96'(17));
`else
        chk("post_rst_bin0", 96'(led_count[0]), 96'(16));
`endif
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
